multi_region_readout: RTL

- Parametrised successor to the single-region BRAM-to-UART dump controller.
- Streams up to NUM_REGIONS memory regions (compressed store, uncompressed byte lanes, etc.) as framed packets over a byte valid/ready stream, normally into the UART transmitter.
- Each packet carries a sync byte, region id, 16-bit length, payload and a one-byte check trailer.
- The read side supports configurable read latency (0 = combinational read, 1+ = registered BRAM).

---
 rtl/readout_pkg.sv | 29 ++
 rtl/readout_check.sv | 28 ++
 rtl/multi_region_readout.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared types and helpers for the multi-region readout controller.
package readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_HDR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_SEND,
    ST_TRAILER,
    ST_DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         HDR_BYTES     = 4;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/readout_check.sv
// Packet check-byte accumulator: modulo-256 sum by default, CRC-8 when
// READOUT_CRC8_EN is defined.
module readout_check
  import readout_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] check
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      check <= '0;
    end else if (clear) begin
      check <= '0;
    end else if (en) begin
`ifdef READOUT_CRC8_EN
      check <= crc8_step(check, data);
`else
      check <= check + data;
`endif
    end
  end

endmodule

// File: rtl/multi_region_readout.sv
// Streams masked memory regions as framed packets (sync, id, len16, payload,
// check byte) over a byte valid/ready stream. Trailer type set by READOUT_CRC8_EN.
module multi_region_readout
  import readout_pkg::*;
#(
  parameter int         NUM_REGIONS = 4,
  parameter int         MEMSIZE     = 2048,
  parameter int         RD_LATENCY  = 1,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  localparam int        ADDR_W      = $clog2(MEMSIZE),
  localparam int        LEN_W       = ADDR_W + 1,
  localparam int        REG_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_REGIONS-1:0]       region_mask,
  input  logic [NUM_REGIONS*LEN_W-1:0] region_len,
  output logic                         rd_en,
  output logic [REG_W-1:0]             rd_region,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic [7:0]                   rd_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         done,
  output logic [23:0]                  bytes_sent
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEMSIZE);

  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] pend;
  logic [LEN_W-1:0]       snap_len [NUM_REGIONS];
  logic [REG_W-1:0]       cur_region, sel_idx;
  logic [LEN_W-1:0]       cur_len;
  logic [15:0]            len16;
  logic [1:0]             hdr_idx, wait_cnt;
  logic                   sel_any, xfer, last, ld, ck_en;
  logic [7:0]             ld_byte, hdr_byte, check;

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == '1) ? v : v + 24'd1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
    return (v > MAX_LEN) ? MAX_LEN : v;
  endfunction

  assign xfer  = tx_valid && tx_ready;
  assign rd_en = (state_q == ST_RD_ISSUE);
  assign len16 = 16'(cur_len);
  assign last  = ({1'b0, rd_addr} == (cur_len - LEN_W'(1)));

  // Lowest pending region wins.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_idx = REG_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    case (hdr_idx)
      2'd0:    hdr_byte = SYNC_BYTE;
      2'd1:    hdr_byte = 8'(cur_region);
      2'd2:    hdr_byte = len16[7:0];
      default: hdr_byte = len16[15:8];
    endcase
  end

  // Byte loads into the output register; the sync byte is not checksummed.
  always_comb begin
    ld      = 1'b0;
    ld_byte = '0;
    ck_en   = 1'b0;
    case (state_q)
      ST_HDR: if (!tx_valid) begin
        ld      = 1'b1;
        ld_byte = hdr_byte;
        ck_en   = (hdr_idx != 2'd0);
      end
      ST_RD_ISSUE: if (RD_LATENCY == 0) begin
        ld      = 1'b1;
        ld_byte = rd_data;
        ck_en   = 1'b1;
      end
      ST_RD_WAIT: if (wait_cnt == 2'(RD_LATENCY)) begin
        ld      = 1'b1;
        ld_byte = rd_data;
        ck_en   = 1'b1;
      end
      ST_TRAILER: if (!tx_valid) begin
        ld      = 1'b1;
        ld_byte = check;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (start && !abort && |region_mask) state_d = ST_SELECT;
        ST_SELECT:   state_d = sel_any ? ST_HDR : ST_DONE;
        ST_HDR:      if (xfer && hdr_idx == 2'(HDR_BYTES - 1))
                       state_d = (cur_len == '0) ? ST_TRAILER : ST_RD_ISSUE;
        ST_RD_ISSUE: state_d = (RD_LATENCY == 0) ? ST_SEND : ST_RD_WAIT;
        ST_RD_WAIT:  if (ld) state_d = ST_SEND;
        ST_SEND:     if (xfer) state_d = last ? ST_TRAILER : ST_RD_ISSUE;
        ST_TRAILER:  if (xfer) state_d = ST_SELECT;
        ST_DONE:     state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= '0;
      cur_region <= '0;
      cur_len    <= '0;
      hdr_idx    <= '0;
      wait_cnt   <= '0;
      rd_region  <= '0;
      rd_addr    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_sent <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) snap_len[i] <= '0;
    end else begin
      done <= 1'b0;
      // A transfer still counts on the cycle an abort arrives.
      if (xfer) bytes_sent <= sat_inc(bytes_sent);
      if (abort && state_q != ST_IDLE) begin
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (ld) begin
          tx_data  <= ld_byte;
          tx_valid <= 1'b1;
        end else if (xfer) begin
          tx_valid <= 1'b0;
        end
        if (xfer && state_q == ST_HDR) hdr_idx <= hdr_idx + 2'd1;
        case (state_q)
          ST_IDLE: if (start && !abort) begin
            if (|region_mask) begin
              pend       <= region_mask;
              bytes_sent <= '0;
              busy       <= 1'b1;
              for (int i = 0; i < NUM_REGIONS; i++)
                snap_len[i] <= clamp_len(region_len[i*LEN_W +: LEN_W]);
            end else begin
              done <= 1'b1;
            end
          end
          ST_SELECT: if (sel_any) begin
            cur_region <= sel_idx;
            cur_len    <= snap_len[sel_idx];
            hdr_idx    <= '0;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          ST_HDR: if (xfer && hdr_idx == 2'(HDR_BYTES - 1) && cur_len != '0) begin
            rd_addr   <= '0;
            rd_region <= cur_region;
          end
          ST_RD_ISSUE: wait_cnt <= 2'd1;
          ST_RD_WAIT:  if (!ld) wait_cnt <= wait_cnt + 2'd1;
          ST_SEND:     if (xfer && !last) rd_addr <= rd_addr + ADDR_W'(1);
          ST_TRAILER:  if (xfer) pend[cur_region] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  readout_check u_check (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == ST_SELECT),
    .en      (ck_en),
    .data    (ld_byte),
    .check   (check)
  );

endmodule
